// File: rtl/depth_test_writer.sv
// ---------------------------------------------------------------------------
// depth_test_writer
//
// Consumer end of the rasterizer pixel stream. Each valid pixel is range
// checked, its stored depth is read from an external dual-port depth BRAM,
// and if it is strictly nearer the new depth and colour are written to the
// depth BRAM and the colour framebuffer. The block also owns the full-screen
// clear of both buffers between frames.
//
// Handshake: drawing is a pure valid strobe with no ready. A pixel presented
// with drawing=1 is consumed on that clock edge; it is either processed
// (IDLE, in range), counted in oob_count (IDLE, out of range) or counted in
// drop_count (busy). No pixel is ever stalled.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   x, y                  pixel coordinates (two's complement, range checked
//                         as unsigned)
//   depth, color          pixel depth (smaller = nearer) and colour
//   drawing               pixel valid
//   clear_start           one-cycle request to clear both buffers
//   zb_rd_addr/zb_rdata   depth BRAM read port (READ_LATENCY cycles)
//   zb_wr_addr/zb_we/zb_wdata  depth BRAM write port
//   fb_addr/fb_we/fb_wdata     colour framebuffer write port
//   busy                  high while draining or clearing
//   clear_done            one-cycle pulse when the clear completes
//   drop_count            pixels dropped while busy (saturating)
//   oob_count             out-of-range pixels discarded (saturating)
//   o_dbg_state           current FSM state (IDLE=0, DRAIN=1, CLEAR=2)
// ---------------------------------------------------------------------------
module depth_test_writer #(
    parameter int COORD_WIDTH     = 32,
    parameter int DEPTH_BIT_WIDTH = 16,
    parameter int COLOR_WIDTH     = 16,
    parameter int FB_WIDTH        = 320,
    parameter int FB_HEIGHT       = 180,
    parameter int READ_LATENCY    = 2,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
    localparam int ADDR_WIDTH     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic [COORD_WIDTH-1:0]     x,
    input  logic [COORD_WIDTH-1:0]     y,
    input  logic [DEPTH_BIT_WIDTH-1:0] depth,
    input  logic [COLOR_WIDTH-1:0]     color,
    input  logic                       drawing,
    input  logic                       clear_start,
    output logic [ADDR_WIDTH-1:0]      zb_rd_addr,
    input  logic [DEPTH_BIT_WIDTH-1:0] zb_rdata,
    output logic [ADDR_WIDTH-1:0]      zb_wr_addr,
    output logic                       zb_we,
    output logic [DEPTH_BIT_WIDTH-1:0] zb_wdata,
    output logic [ADDR_WIDTH-1:0]      fb_addr,
    output logic                       fb_we,
    output logic [COLOR_WIDTH-1:0]     fb_wdata,
    output logic                       busy,
    output logic                       clear_done,
    output logic [15:0]                drop_count,
    output logic [15:0]                oob_count,
    output logic [1:0]                 o_dbg_state
);

    localparam int RL = READ_LATENCY;
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    localparam logic [ADDR_WIDTH-1:0]  FBW_A     = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [COORD_WIDTH-1:0] W_LIM     = COORD_WIDTH'(FB_WIDTH);
    localparam logic [COORD_WIDTH-1:0] H_LIM     = COORD_WIDTH'(FB_HEIGHT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_clear_done;
    logic [15:0]           r_drop;
    logic [15:0]           r_oob;

    // Pixel pipeline: index 0 is the cycle the read address is presented,
    // index RL is the cycle the read data returns and the test is made.
    logic [RL:0]                r_v;
    logic [ADDR_WIDTH-1:0]      r_a [0:RL];
    logic [DEPTH_BIT_WIDTH-1:0] r_d [0:RL];
    logic [COLOR_WIDTH-1:0]     r_c [0:RL];

    // Registered write port (shared by depth and colour buffers).
    logic                       r_zb_we;
    logic                       r_fb_we;
    logic [ADDR_WIDTH-1:0]      r_wa;
    logic [DEPTH_BIT_WIDTH-1:0] r_zb_wd;
    logic [COLOR_WIDTH-1:0]     r_fb_wd;

    // Writes issued in the RL cycles before the current output register.
    // Together with the output register these are the RL+1 writes that the
    // BRAM had not yet committed when the tested pixel's read was sampled.
    logic [RL-1:0]              r_h_we;
    logic [ADDR_WIDTH-1:0]      r_h_a [0:RL-1];
    logic [DEPTH_BIT_WIDTH-1:0] r_h_d [0:RL-1];

    logic                       w_in_range;
    logic [ADDR_WIDTH-1:0]      w_addr;
    logic                       w_idle_ok;
    logic                       w_accept;
    logic                       w_drop;
    logic                       w_oob;
    logic                       w_pipe_empty;
    logic [DEPTH_BIT_WIDTH-1:0] w_stored;
    logic                       w_pass;

    // Negative coordinates are huge when viewed unsigned, so one compare
    // per axis rejects both sides of the screen.
    assign w_in_range   = (x < W_LIM) && (y < H_LIM);
    assign w_addr       = y[ADDR_WIDTH-1:0] * FBW_A + x[ADDR_WIDTH-1:0];
    // The clear_done cycle still belongs to the clear for pixel acceptance.
    assign w_idle_ok    = (r_state == S_IDLE) && !r_clear_done;
    assign w_accept     = drawing && w_idle_ok && w_in_range;
    assign w_drop       = drawing && !w_idle_ok;
    assign w_oob        = drawing && w_idle_ok && !w_in_range;
    assign w_pipe_empty = (r_v == '0);

    // Forwarding: walk oldest to newest so the most recent match wins.
    always_comb begin
        w_stored = zb_rdata;
        for (int k = RL - 1; k >= 0; k--) begin
            if (r_h_we[k] && (r_h_a[k] == r_a[RL])) w_stored = r_h_d[k];
        end
        if (r_zb_we && (r_wa == r_a[RL])) w_stored = r_zb_wd;
    end

    assign w_pass = r_v[RL] && (r_d[RL] < w_stored);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_clear_done <= 1'b0;
            r_drop       <= '0;
            r_oob        <= '0;
            r_v          <= '0;
            r_zb_we      <= 1'b0;
            r_fb_we      <= 1'b0;
            r_wa         <= '0;
            r_zb_wd      <= '0;
            r_fb_wd      <= '0;
            r_h_we       <= '0;
            for (int k = 0; k <= RL; k++) begin
                r_a[k] <= '0;
                r_d[k] <= '0;
                r_c[k] <= '0;
            end
            for (int k = 0; k < RL; k++) begin
                r_h_a[k] <= '0;
                r_h_d[k] <= '0;
            end
        end else begin
            // Pixel pipeline advance.
            r_v    <= {r_v[RL-1:0], w_accept};
            r_a[0] <= w_addr;
            r_d[0] <= depth;
            r_c[0] <= color;
            for (int k = 1; k <= RL; k++) begin
                r_a[k] <= r_a[k-1];
                r_d[k] <= r_d[k-1];
                r_c[k] <= r_c[k-1];
            end

            // Write history shifts in whatever the output register holds now.
            r_h_we[0] <= r_zb_we;
            r_h_a[0]  <= r_wa;
            r_h_d[0]  <= r_zb_wd;
            for (int k = 1; k < RL; k++) begin
                r_h_we[k] <= r_h_we[k-1];
                r_h_a[k]  <= r_h_a[k-1];
                r_h_d[k]  <= r_h_d[k-1];
            end

            // Write port. CLEAR only starts once the pipeline is empty, so
            // the two sources never compete.
            if (r_state == S_CLEAR) begin
                r_zb_we <= 1'b1;
                r_fb_we <= 1'b1;
                r_wa    <= r_clr_addr;
                r_zb_wd <= '1;
                r_fb_wd <= CLEAR_COLOR;
            end else if (w_pass) begin
                r_zb_we <= 1'b1;
                r_fb_we <= 1'b1;
                r_wa    <= r_a[RL];
                r_zb_wd <= r_d[RL];
                r_fb_wd <= r_c[RL];
            end else begin
                r_zb_we <= 1'b0;
                r_fb_we <= 1'b0;
            end

            // Control FSM.
            r_clear_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_start) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_pipe_empty) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state      <= S_IDLE;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Saturating event counters.
            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
            if (w_oob && (r_oob != 16'hFFFF)) r_oob <= r_oob + 16'd1;
        end
    end

    assign zb_rd_addr  = r_a[0];
    assign zb_wr_addr  = r_wa;
    assign zb_we       = r_zb_we;
    assign zb_wdata    = r_zb_wd;
    assign fb_addr     = r_wa;
    assign fb_we       = r_fb_we;
    assign fb_wdata    = r_fb_wd;
    assign busy        = (r_state != S_IDLE);
    assign clear_done  = r_clear_done;
    assign drop_count  = r_drop;
    assign oob_count   = r_oob;
    assign o_dbg_state = r_state;

endmodule
